// File: rtl/mem_arbiter2_pkg.sv
// Shared definitions for the two-port memory arbiter: the owner encoding
// and parameter defaults.
package mem_arbiter2_pkg;

  localparam int WIDTH_DEFAULT  = 13;
  localparam int STARVE_DEFAULT = 4;
  localparam int DATA_W         = 32;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DLOAD  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter2_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the
// single-ported memory.
interface mem_arbiter2_if
  import mem_arbiter2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic              i_valid;
  logic [WIDTH-1:0]  i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_valid;
  logic              d_write;
  logic [3:0]        d_wmask;
  logic [DATA_W-1:0] d_wdata;
  logic [WIDTH-1:0]  d_addr;
  logic              d_ready;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_valid;
  logic              mem_write;
  logic [3:0]        mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [WIDTH-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_valid, i_addr,
    output i_ready, i_rvalid, i_rdata,
    input  d_valid, d_write, d_wmask, d_wdata, d_addr,
    output d_ready, d_rvalid, d_rdata,
    output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    input  mem_rdata
  );

  modport master (
    output i_valid, i_addr,
    input  i_ready, i_rvalid, i_rdata,
    output d_valid, d_write, d_wmask, d_wdata, d_addr,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_starve.sv
// Saturating count of data grants taken while fetch was waiting; raises
// force_i once fetch has been passed over STARVE times in a row.
module mem_arb_starve
  import mem_arbiter2_pkg::*;
#(
  parameter int STARVE = STARVE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic       gnt_i,
  input  logic       gnt_d,
  output logic [3:0] starve_cnt,
  output logic       force_i
);

  localparam logic [3:0] STARVE_L = 4'(STARVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (gnt_i || !i_valid) begin
      starve_cnt <= 4'd0;
    end else if (gnt_d && starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_i = (starve_cnt >= STARVE_L);

endmodule

// File: rtl/mem_arbiter2.sv
// Shares one single-ported, one-cycle-latency memory between instruction
// fetch and load/store; data has priority, with a starvation guard for fetch.
module mem_arbiter2
  import mem_arbiter2_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int STARVE = STARVE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter2_if.slave bus
);

  logic             gnt_i;
  logic             gnt_d;
  logic             force_i;
  logic [3:0]       starve_cnt;
  logic [WIDTH-1:0] addr_hold;
  owner_e           owner_q;
  owner_e           owner_d;

  mem_arb_starve #(
    .STARVE(STARVE)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (bus.i_valid),
    .gnt_i     (gnt_i),
    .gnt_d     (gnt_d),
    .starve_cnt(starve_cnt),
    .force_i   (force_i)
  );

  always_comb begin
    gnt_d = bus.d_valid & ~(bus.i_valid & force_i);
    gnt_i = bus.i_valid & ~gnt_d;
  end

  assign bus.i_ready   = gnt_i & ~rst;
  assign bus.d_ready   = gnt_d & ~rst;

  assign bus.mem_valid = (gnt_i | gnt_d) & ~rst;
  assign bus.mem_write = gnt_d & bus.d_write;
  assign bus.mem_wmask = gnt_d ? bus.d_wmask : 4'd0;
  assign bus.mem_wdata = gnt_d ? bus.d_wdata : '0;

  // Idle cycles keep presenting the last granted address to the memory.
  assign bus.mem_addr  = gnt_d ? bus.d_addr :
                         gnt_i ? bus.i_addr : addr_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold <= '0;
    end else if (gnt_i || gnt_d) begin
      addr_hold <= bus.mem_addr;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (rst) begin
      owner_d = OWN_NONE;
    end else if (gnt_i) begin
      owner_d = OWN_IFETCH;
    end else if (gnt_d && !bus.d_write) begin
      owner_d = OWN_DLOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // A read still in flight when reset arrives is discarded, not returned.
  assign bus.i_rvalid = (owner_q == OWN_IFETCH) & ~rst;
  assign bus.d_rvalid = (owner_q == OWN_DLOAD) & ~rst;
  assign bus.i_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Randomised and directed bench for mem_arbiter2 in front of a 32-bit
// single-ported memory, checked against a transaction-level reference model.
module tb_mem_arbiter2;
  import mem_arbiter2_pkg::*;

  localparam int W     = 13;
  localparam int ST    = 4;
  localparam int DEPTH = 1 << W;

  typedef struct {
    logic        i_ready, d_ready, i_rvalid, d_rvalid, mem_valid, mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [W-1:0] mem_addr;
    logic [31:0] i_rdata, d_rdata;
  } sample_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter2_if #(.WIDTH(W)) bus ();

  mem_arbiter2 #(.WIDTH(W), .STARVE(ST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory instance: free-running read, byte-masked write.
  logic [31:0] mem_array [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.mem_valid && bus.mem_write)
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask[b]) mem_array[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    bus.mem_rdata <= mem_array[bus.mem_addr];
  end

  // Reference model state: expected memory, the pending read, fetch wait count.
  logic [31:0]  ref_mem [0:DEPTH-1];
  int           pend;
  logic [31:0]  pend_data;
  logic [W-1:0] last_addr;
  int           waits;
  int           checks;
  int           failures;

  task automatic set_idle();
    bus.i_valid = 1'b0; bus.i_addr = '0;
    bus.d_valid = 1'b0; bus.d_write = 1'b0; bus.d_wmask = 4'd0;
    bus.d_wdata = 32'd0; bus.d_addr = '0;
  endtask

  task automatic run_cycle(output sample_t o, output sample_t e);
    logic gd, gi;
    @(negedge clk);
    o.i_ready = bus.i_ready;     o.d_ready = bus.d_ready;
    o.i_rvalid = bus.i_rvalid;   o.d_rvalid = bus.d_rvalid;
    o.mem_valid = bus.mem_valid; o.mem_write = bus.mem_write;
    o.mem_wmask = bus.mem_wmask; o.mem_wdata = bus.mem_wdata;
    o.mem_addr = bus.mem_addr;
    o.i_rdata = bus.i_rdata;     o.d_rdata = bus.d_rdata;
    gd = bus.d_valid && !(bus.i_valid && waits >= ST);
    gi = bus.i_valid && !gd;
    e.i_ready   = gi && !rst;
    e.d_ready   = gd && !rst;
    e.mem_valid = (gi || gd) && !rst;
    e.mem_write = gd && bus.d_write;
    e.mem_wmask = gd ? bus.d_wmask : 4'd0;
    e.mem_wdata = gd ? bus.d_wdata : 32'd0;
    e.mem_addr  = gd ? bus.d_addr : (gi ? bus.i_addr : last_addr);
    e.i_rvalid  = !rst && pend == 1;
    e.d_rvalid  = !rst && pend == 2;
    e.i_rdata   = pend_data;
    e.d_rdata   = pend_data;
    if (rst) begin
      pend = 0; waits = 0; last_addr = '0;
    end else begin
      if (gd && bus.d_write)
        for (int b = 0; b < 4; b++)
          if (bus.d_wmask[b]) ref_mem[bus.d_addr][8*b +: 8] = bus.d_wdata[8*b +: 8];
      pend      = gi ? 1 : ((gd && !bus.d_write) ? 2 : 0);
      pend_data = gi ? ref_mem[bus.i_addr] : ref_mem[bus.d_addr];
      if (gi || gd) last_addr = e.mem_addr;
      if (gi || !bus.i_valid) waits = 0;
      else if (waits < 15) waits++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sample_t o, e;
    rst = 1'b1;
    set_idle();
    run_cycle(o, e);
    run_cycle(o, e);
    checks++; if (o.i_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_i_ready got=%0b exp=0", o.i_ready); end
    checks++; if (o.d_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_d_ready got=%0b exp=0", o.d_ready); end
    checks++; if (o.i_rvalid !== 1'b0 || o.d_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid got=%0b%0b exp=00", o.i_rvalid, o.d_rvalid); end
    checks++; if (o.mem_valid !== 1'b0 || o.mem_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_strobes got=%0b%0b exp=00", o.mem_valid, o.mem_write); end
    checks++; if (o.mem_wmask !== 4'd0 || o.mem_wdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_mem_wr got=%h/%h exp=0/0", o.mem_wmask, o.mem_wdata); end
    checks++; if (o.mem_addr !== 13'd0) begin failures++; $display("[TB] FAIL reset_mem_addr got=%0d exp=0", o.mem_addr); end
    checks++; if (dut.starve_cnt !== 4'd0) begin failures++; $display("[TB] FAIL reset_starve got=%0d exp=0", dut.starve_cnt); end
    bus.i_valid = 1'b1; bus.d_valid = 1'b1;
    run_cycle(o, e);
    checks++; if (o.i_ready !== 1'b0 || o.d_ready !== 1'b0 || o.mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_ready got=%0b%0b%0b exp=000", o.i_ready, o.d_ready, o.mem_valid); end
    rst = 1'b0;
    set_idle();
    run_cycle(o, e);
  endtask

  task automatic test_fetch_only();
    sample_t o, e;
    logic [31:0] pre [3];
    pre[0] = 32'h11111111; pre[1] = 32'h22222222; pre[2] = 32'h33333333;
    for (int k = 0; k < 4; k++) begin
      set_idle();
      if (k < 3) begin bus.i_valid = 1'b1; bus.i_addr = 13'(k); end
      run_cycle(o, e);
      if (k < 3) begin
        checks++; if (o.i_ready !== 1'b1) begin failures++; $display("[TB] FAIL fetch_ready k=%0d got=%0b exp=1", k, o.i_ready); end
        checks++; if (o.mem_addr !== 13'(k)) begin failures++; $display("[TB] FAIL fetch_addr k=%0d got=%0d exp=%0d", k, o.mem_addr, k); end
      end
      if (k > 0) begin
        checks++; if (o.i_rvalid !== 1'b1 || o.i_rdata !== pre[k-1]) begin failures++; $display("[TB] FAIL fetch_data k=%0d got=%0b/%h exp=1/%h", k, o.i_rvalid, o.i_rdata, pre[k-1]); end
      end
      checks++; if (o.d_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL fetch_d_rvalid k=%0d got=%0b exp=0", k, o.d_rvalid); end
    end
  endtask

  task automatic test_contention();
    sample_t o, e;
    logic exp_d;
    set_idle();
    run_cycle(o, e);
    bus.i_valid = 1'b1; bus.d_valid = 1'b1;
    bus.i_addr = 13'(32 + $urandom_range(0, 31));
    bus.d_addr = 13'(32 + $urandom_range(0, 31));
    for (int k = 0; k < 16; k++) begin
      if (k == 15) set_idle();
      run_cycle(o, e);
      exp_d = (k % 5) != 4;
      if (k < 15) begin
        checks++; if (o.d_ready !== exp_d || o.i_ready !== !exp_d) begin failures++; $display("[TB] FAIL contention_grant k=%0d got=d%0b/i%0b exp=d%0b/i%0b", k, o.d_ready, o.i_ready, exp_d, !exp_d); end
      end
      if (k > 0) begin
        checks++; if (o.i_rvalid !== e.i_rvalid || o.d_rvalid !== e.d_rvalid) begin failures++; $display("[TB] FAIL contention_rvalid k=%0d got=%0b%0b exp=%0b%0b", k, o.i_rvalid, o.d_rvalid, e.i_rvalid, e.d_rvalid); end
        checks++; if ((e.i_rvalid ? o.i_rdata : o.d_rdata) !== e.i_rdata) begin failures++; $display("[TB] FAIL contention_rdata k=%0d got=%h/%h exp=%h", k, o.i_rdata, o.d_rdata, e.i_rdata); end
      end
      if (o.i_ready) bus.i_addr = 13'(32 + $urandom_range(0, 31));
      if (o.d_ready) bus.d_addr = 13'(32 + $urandom_range(0, 31));
    end
  endtask

  task automatic test_store_load();
    sample_t o, e;
    set_idle();
    bus.d_valid = 1'b1; bus.d_write = 1'b1; bus.d_wmask = 4'b0011;
    bus.d_wdata = 32'hDEADBEEF; bus.d_addr = 13'd5;
    run_cycle(o, e);
    checks++; if (o.d_ready !== 1'b1 || o.mem_write !== 1'b1 || o.mem_wmask !== 4'b0011) begin failures++; $display("[TB] FAIL store_issue got=%0b%0b/%b exp=11/0011", o.d_ready, o.mem_write, o.mem_wmask); end
    bus.d_write = 1'b0; bus.d_wmask = 4'd0; bus.d_wdata = 32'd0;
    run_cycle(o, e);
    checks++; if (o.d_rvalid !== 1'b0 || o.i_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL store_no_rvalid got=%0b%0b exp=00", o.d_rvalid, o.i_rvalid); end
    checks++; if (o.d_ready !== 1'b1) begin failures++; $display("[TB] FAIL load_ready got=%0b exp=1", o.d_ready); end
    set_idle();
    run_cycle(o, e);
    checks++; if (o.d_rvalid !== 1'b1 || o.d_rdata !== 32'hAAAABEEF) begin failures++; $display("[TB] FAIL store_load_data got=%0b/%h exp=1/aaaabeef", o.d_rvalid, o.d_rdata); end
  endtask

  task automatic test_idle_hold();
    sample_t o, e;
    set_idle();
    bus.d_valid = 1'b1; bus.d_addr = 13'd7;
    run_cycle(o, e);
    checks++; if (o.mem_addr !== 13'd7) begin failures++; $display("[TB] FAIL hold_load_addr got=%0d exp=7", o.mem_addr); end
    set_idle();
    for (int k = 0; k < 3; k++) begin
      run_cycle(o, e);
      checks++; if (o.mem_addr !== 13'd7 || o.mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_idle k=%0d got=%0d/%0b exp=7/0", k, o.mem_addr, o.mem_valid); end
      checks++; if (o.d_rvalid !== (k == 0) || o.i_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL hold_rvalid k=%0d got=d%0b/i%0b exp=d%0b/i0", k, o.d_rvalid, o.i_rvalid, (k == 0)); end
      if (k == 0) begin
        checks++; if (o.d_rdata !== e.d_rdata) begin failures++; $display("[TB] FAIL hold_rdata got=%h exp=%h", o.d_rdata, e.d_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    sample_t o, e;
    set_idle();
    bus.i_valid = 1'b1; bus.i_addr = 13'd9;
    run_cycle(o, e);
    checks++; if (o.i_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_grant got=%0b exp=1", o.i_ready); end
    rst = 1'b1;
    bus.i_addr = 13'd10; bus.d_valid = 1'b1; bus.d_addr = 13'd11;
    run_cycle(o, e);
    checks++; if (o.i_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_rvalid_t1 got=%0b exp=0", o.i_rvalid); end
    checks++; if (o.i_ready !== 1'b0 || o.d_ready !== 1'b0 || o.mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_ready got=%0b%0b%0b exp=000", o.i_ready, o.d_ready, o.mem_valid); end
    checks++; if (dut.starve_cnt !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_starve got=%0d exp=0", dut.starve_cnt); end
    rst = 1'b0;
    set_idle();
    run_cycle(o, e);
    checks++; if (o.i_rvalid !== 1'b0 || o.d_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_rvalid_t2 got=%0b%0b exp=00", o.i_rvalid, o.d_rvalid); end
    bus.i_valid = 1'b1; bus.i_addr = 13'd10;
    run_cycle(o, e);
    checks++; if (o.i_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_regrant got=%0b exp=1", o.i_ready); end
    set_idle();
    run_cycle(o, e);
    checks++; if (o.i_rvalid !== 1'b1 || o.i_rdata !== ref_mem[10]) begin failures++; $display("[TB] FAIL rstmid_refetch got=%0b/%h exp=1/%h", o.i_rvalid, o.i_rdata, ref_mem[10]); end
  endtask

  task automatic test_fetch_withdrawn();
    sample_t o, e;
    set_idle();
    run_cycle(o, e);
    bus.i_valid = 1'b1; bus.i_addr = 13'd40; bus.d_valid = 1'b1; bus.d_addr = 13'd41;
    for (int k = 0; k < 3; k++) begin
      run_cycle(o, e);
      checks++; if (o.d_ready !== 1'b1 || o.i_ready !== 1'b0) begin failures++; $display("[TB] FAIL withdraw_pre k=%0d got=d%0b/i%0b exp=d1/i0", k, o.d_ready, o.i_ready); end
    end
    checks++; if (dut.starve_cnt !== 4'd3) begin failures++; $display("[TB] FAIL withdraw_count got=%0d exp=3", dut.starve_cnt); end
    bus.i_valid = 1'b0;
    run_cycle(o, e);
    checks++; if (dut.starve_cnt !== 4'd0) begin failures++; $display("[TB] FAIL withdraw_clear got=%0d exp=0", dut.starve_cnt); end
    bus.i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_cycle(o, e);
      checks++; if (o.d_ready !== (k != 4) || o.i_ready !== (k == 4)) begin failures++; $display("[TB] FAIL withdraw_post k=%0d got=d%0b/i%0b exp=d%0b/i%0b", k, o.d_ready, o.i_ready, (k != 4), (k == 4)); end
    end
    set_idle();
    run_cycle(o, e);
  endtask

  task automatic test_random();
    sample_t o, e;
    set_idle();
    for (int c = 0; c < 400; c++) begin
      if (!bus.i_valid && $urandom_range(0, 99) < 60) begin
        bus.i_valid = 1'b1; bus.i_addr = 13'($urandom_range(0, 31));
      end
      if (!bus.d_valid && $urandom_range(0, 99) < 60) begin
        bus.d_valid = 1'b1; bus.d_addr = 13'($urandom_range(0, 31));
        bus.d_write = ($urandom_range(0, 2) == 0);
        bus.d_wmask = 4'($urandom_range(0, 15)); bus.d_wdata = $urandom;
      end
      rst = ($urandom_range(0, 63) == 0);
      run_cycle(o, e);
      checks++; if (o.i_ready !== e.i_ready || o.d_ready !== e.d_ready) begin failures++; $display("[TB] FAIL rand_ready c=%0d got=i%0b/d%0b exp=i%0b/d%0b", c, o.i_ready, o.d_ready, e.i_ready, e.d_ready); end
      checks++; if (o.i_rvalid !== e.i_rvalid || o.d_rvalid !== e.d_rvalid) begin failures++; $display("[TB] FAIL rand_rvalid c=%0d got=i%0b/d%0b exp=i%0b/d%0b", c, o.i_rvalid, o.d_rvalid, e.i_rvalid, e.d_rvalid); end
      checks++; if (o.mem_valid !== e.mem_valid || o.mem_write !== e.mem_write) begin failures++; $display("[TB] FAIL rand_mem_strobe c=%0d got=%0b%0b exp=%0b%0b", c, o.mem_valid, o.mem_write, e.mem_valid, e.mem_write); end
      checks++; if (o.mem_addr !== e.mem_addr) begin failures++; $display("[TB] FAIL rand_mem_addr c=%0d got=%0d exp=%0d", c, o.mem_addr, e.mem_addr); end
      checks++; if (o.mem_wmask !== e.mem_wmask || o.mem_wdata !== e.mem_wdata) begin failures++; $display("[TB] FAIL rand_mem_wr c=%0d got=%b/%h exp=%b/%h", c, o.mem_wmask, o.mem_wdata, e.mem_wmask, e.mem_wdata); end
      if (e.i_rvalid) begin
        checks++; if (o.i_rdata !== e.i_rdata) begin failures++; $display("[TB] FAIL rand_i_rdata c=%0d got=%h exp=%h", c, o.i_rdata, e.i_rdata); end
      end
      if (e.d_rvalid) begin
        checks++; if (o.d_rdata !== e.d_rdata) begin failures++; $display("[TB] FAIL rand_d_rdata c=%0d got=%h exp=%h", c, o.d_rdata, e.d_rdata); end
      end
      if (o.i_ready) bus.i_valid = 1'b0;
      if (o.d_ready) bus.d_valid = 1'b0;
    end
    rst = 1'b0;
    set_idle();
    run_cycle(o, e);
  endtask

  initial begin
    checks = 0; failures = 0;
    pend = 0; pend_data = 32'd0; last_addr = '0; waits = 0;
    for (int a = 0; a < DEPTH; a++) begin
      ref_mem[a] = $urandom;
      mem_array[a] = ref_mem[a];
    end
    ref_mem[0] = 32'h11111111; mem_array[0] = 32'h11111111;
    ref_mem[1] = 32'h22222222; mem_array[1] = 32'h22222222;
    ref_mem[2] = 32'h33333333; mem_array[2] = 32'h33333333;
    ref_mem[5] = 32'hAAAAAAAA; mem_array[5] = 32'hAAAAAAAA;
    $display("[TB] starting mem_arbiter2 bench");
    test_reset();
    test_fetch_only();
    test_contention();
    test_store_load();
    test_idle_hold();
    test_reset_mid_read();
    test_fetch_withdrawn();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Shares one single-ported, 32-bit, one-cycle-read-latency synchronous memory between two requesters: instruction fetch (i_*) and load/store (d_*).
- Sits between the core's two bus ports and the memory instance.
- Grants at most one access per cycle and routes read data back to the owner one cycle later.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- WIDTH, 13, word-address width, equal to the memory's address width.
- STARVE, 4, maximum consecutive data grants while i_valid waits before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_valid  in  1  fetch request
- i_addr  in  WIDTH  fetch word address
- i_ready  out  1  fetch request accepted this cycle
- i_rvalid  out  1  i_rdata valid this cycle
- i_rdata  out  32  fetch read data
- d_valid  in  1  data request
- d_write  in  1  1 = store, 0 = load
- d_wmask  in  4  byte enables, bit n covers bits 8n+7:8n
- d_wdata  in  32  store data
- d_addr  in  WIDTH  data word address
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid this cycle (loads only)
- d_rdata  out  32  load data
- mem_valid  out  1  memory access strobe
- mem_write  out  1  memory write
- mem_wmask  out  4  memory byte enables
- mem_wdata  out  32  memory write data
- mem_addr  out  WIDTH  memory word address
- mem_rdata  in  32  memory read data, registered in the memory, valid one cycle after the address

Behaviour:
- Grant is combinational in the request cycle.
  - gnt_d = d_valid & ~(i_valid & force_i)
  - gnt_i = i_valid & ~gnt_d
  - force_i = (starve_cnt >= STARVE)
- Ready signals: i_ready = gnt_i & ~rst and d_ready = gnt_d & ~rst. A request is accepted on a cycle with valid & ready. The requester holds valid, addr and data stable until accepted.
- Memory port:
  - mem_valid = (gnt_i | gnt_d) & ~rst.
  - mem_write = gnt_d & d_write.
  - mem_wmask and mem_wdata come from the d port when gnt_d, else 0.
  - mem_addr is the granted address. When idle, mem_addr holds the last granted address (register addr_hold, reset 0), so the free-running memory read does not disturb anything.
- Owner register (state machine), 2 bits: NONE, IFETCH, DLOAD. Reset value NONE.
  - Next state is IFETCH if gnt_i; else DLOAD if gnt_d & ~d_write; else NONE (this covers both stores and idle).
  - Transitions are suppressed to NONE during rst.
- Return path:
  - i_rvalid = (owner == IFETCH); d_rvalid = (owner == DLOAD).
  - i_rdata = d_rdata = mem_rdata, unregistered.
  - Read latency is exactly 1 cycle after acceptance. Data is valid only in the rvalid cycle; the requester samples it then.
  - Stores produce no rvalid.
- Starvation counter starve_cnt (4 bits, reset 0):
  - Increments, saturating at 15, on cycles with gnt_d & i_valid.
  - Clears on gnt_i or on ~i_valid.
  - Consequence: with both ports continuously valid, the grant sequence is STARVE data grants, then 1 fetch grant, repeating.
- Back-to-back operation:
  - A new grant may issue in the same cycle as the previous owner's rvalid.
  - Full throughput is one access per cycle with no bubbles.
- Simultaneous events:
  - A store and a fetch to the same address in the same cycle cannot occur, because only one is granted.
  - A load issued the cycle after a store to the same address returns the new data; the memory write completes at that edge.
- Reset:
  - Reset mid-operation discards any in-flight read. The rvalid outputs are 0 in the cycle after rst is high.
  - All ready and mem_valid outputs are 0 while rst is high.
  - Output values after reset: i_ready = 0, d_ready = 0, i_rvalid = 0, d_rvalid = 0, mem_valid = 0, mem_write = 0, mem_wmask = 0, mem_wdata = 0, mem_addr = 0, starve_cnt = 0.

Decomposition:
- Shared package holds:
  - owner encoding constants OWN_NONE = 2'd0, OWN_IFETCH = 2'd1, OWN_DLOAD = 2'd2;
  - the STARVE default.
- One natural sub-module: mem_arb_starve, the saturating starvation counter plus the force_i compare.
- Everything else sits in mem_arbiter2.
- The bench instantiates mem_arbiter2 in front of the team's 32-bit single-ported memory model.

Test Plan:
- Fetch only:
  - Stimulus: i_valid = 1 for addresses 0, 1, 2, with memory preloaded 0x11111111, 0x22222222, 0x33333333.
  - Required response: i_ready = 1 on each cycle; i_rvalid = 1 one cycle later with the matching data; d_rvalid stays 0.
- Contention:
  - Stimulus: i_valid = d_valid = 1 continuously (loads), STARVE = 4.
  - Required response: grant pattern D, D, D, D, I repeating; each rvalid lands on the correct port with the correct address data.
- Store then load:
  - Stimulus: store 0xDEADBEEF with wmask 4'b0011 to address 5 (old content 0xAAAAAAAA); load address 5 the next cycle.
  - Required response: d_rdata = 0xAAAABEEF; no rvalid for the store cycle.
- Idle hold:
  - Stimulus: load address 7, then 3 idle cycles.
  - Required response: mem_addr stays 7; mem_valid = 0; i_rvalid and d_rvalid both 0 after the single load return.
- Reset mid-read:
  - Stimulus: fetch granted at cycle t, rst = 1 at cycle t+1.
  - Required response: i_rvalid = 0 at t+1 and t+2; starve_cnt = 0; the first request after rst deasserts is granted normally.
- Fetch withdrawn:
  - Stimulus: fetch waits 3 data grants, then i_valid drops.
  - Required response: starve_cnt returns to 0; the next contention again allows the full STARVE data grants.
